// File: rtl/spi_slave_regfile.sv
// SPI mode-0 target holding a small register bank; SCLK/CS_N/MOSI are oversampled
// by clk, a local port preloads registers and SPI writes are reported as pulses.
module spi_slave_regfile #(
   parameter int W_DATA = 32,
   parameter int W_ADDR = 3,
   parameter int W_CMD  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic              ld_en,
   input  logic [W_ADDR-1:0] ld_addr,
   input  logic [W_DATA-1:0] ld_data,
   output logic              wr_valid,
   output logic [W_ADDR-1:0] wr_addr,
   output logic [W_DATA-1:0] wr_data,
   output logic              frame_err
);

   localparam int unsigned N_REGS = 2 ** W_ADDR;
   localparam int          W_MAX  = (W_DATA > W_CMD) ? W_DATA : W_CMD;
   localparam int          W_CNT  = $clog2(W_MAX + 1);
   localparam logic [W_CNT-1:0] CMD_LAST  = W_CNT'(W_CMD - 1);
   localparam logic [W_CNT-1:0] DATA_LAST = W_CNT'(W_DATA - 1);

   typedef enum logic [2:0] {IDLE, CMD, DATA_WR, DATA_RD, WAIT_CS} state_t;

   logic              sclk_s1, sclk_s2, sclk_q;
   logic              cs_s1, cs_s2, cs_q;
   logic              mosi_s1, mosi_s2;
   logic              sclk_rise, sclk_fall, cs_fall;

   logic [W_DATA-1:0] regs [N_REGS];
   state_t            state;
   logic [W_CNT-1:0]  bit_cnt;
   logic [W_CMD-1:0]  cmd_sr;
   logic [W_CMD-1:0]  cmd_next;
   logic [W_ADDR-1:0] addr;
   logic [W_DATA-1:0] shreg;
   logic              rd_load;
   logic              commit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_s1 <= 1'b0;
         sclk_s2 <= 1'b0;
         sclk_q  <= 1'b0;
         cs_s1   <= 1'b1;
         cs_s2   <= 1'b1;
         cs_q    <= 1'b1;
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
         miso_oe <= 1'b0;
      end else begin
         sclk_s1 <= sclk;
         sclk_s2 <= sclk_s1;
         sclk_q  <= sclk_s2;
         cs_s1   <= cs_n;
         cs_s2   <= cs_s1;
         cs_q    <= cs_s2;
         mosi_s1 <= mosi;
         mosi_s2 <= mosi_s1;
         miso_oe <= ~cs_s2;
      end
   end

   always_comb begin
      sclk_rise = sclk_s2 & ~sclk_q;
      sclk_fall = ~sclk_s2 & sclk_q;
      cs_fall   = ~cs_s2 & cs_q;
      cmd_next  = {cmd_sr[W_CMD-2:0], mosi_s2};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         cmd_sr    <= '0;
         addr      <= '0;
         shreg     <= '0;
         miso      <= 1'b0;
         rd_load   <= 1'b0;
         commit    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         rd_load   <= 1'b0;
         commit    <= 1'b0;
         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state   <= CMD;
                  bit_cnt <= '0;
               end
            end
            CMD: begin
               if (cs_s2) begin
                  state     <= IDLE;
                  frame_err <= 1'b1;
               end else if (sclk_rise) begin
                  cmd_sr <= cmd_next;
                  if (bit_cnt == CMD_LAST) begin
                     bit_cnt <= '0;
                     addr    <= cmd_next[W_ADDR-1:0];
                     if (|cmd_next[W_CMD-2:W_ADDR]) begin
                        frame_err <= 1'b1;
                        state     <= WAIT_CS;
                     end else if (cmd_next[W_CMD-1]) begin
                        state   <= DATA_RD;
                        rd_load <= 1'b1;
                     end else begin
                        state <= DATA_WR;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            DATA_WR: begin
               if (cs_s2) begin
                  state     <= IDLE;
                  frame_err <= 1'b1;
               end else if (sclk_rise) begin
                  shreg <= {shreg[W_DATA-2:0], mosi_s2};
                  if (bit_cnt == DATA_LAST) begin
                     state  <= WAIT_CS;
                     commit <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            DATA_RD: begin
               // The fall that closes the command phase must not shift: bit_cnt
               // stays zero until the first data rise has sampled the MSB.
               if (cs_s2) begin
                  state     <= IDLE;
                  frame_err <= 1'b1;
               end else if (rd_load) begin
                  shreg <= regs[addr];
                  miso  <= regs[addr][W_DATA-1];
               end else if (sclk_rise) begin
                  if (bit_cnt == DATA_LAST) begin
                     state <= WAIT_CS;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else if (sclk_fall && bit_cnt != '0) begin
                  shreg <= {shreg[W_DATA-2:0], 1'b0};
                  miso  <= shreg[W_DATA-2];
               end
            end
            WAIT_CS: begin
               if (cs_s2) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The local preload is applied after the SPI commit so it wins on a same-address collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < N_REGS; i++) regs[i] <= '0;
         wr_valid <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
      end else begin
         wr_valid <= commit;
         if (commit) begin
            regs[addr] <= shreg;
            wr_addr    <= addr;
            wr_data    <= shreg;
         end
         if (ld_en) regs[ld_addr] <= ld_data;
      end
   end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Self-checking bench for spi_slave_regfile: directed scenarios followed by random
// frames, compared against a frame-level register-bank model.
module tb_spi_slave_regfile;

   localparam int W_DATA = 32;
   localparam int W_ADDR = 3;
   localparam int W_CMD  = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              sclk, cs_n, mosi;
   logic              miso, miso_oe;
   logic              ld_en;
   logic [W_ADDR-1:0] ld_addr;
   logic [W_DATA-1:0] ld_data;
   logic              wr_valid;
   logic [W_ADDR-1:0] wr_addr;
   logic [W_DATA-1:0] wr_data;
   logic              frame_err;

   int vectors     = 0;
   int miscompares = 0;
   int wr_seen     = 0;
   int err_seen    = 0;
   logic [W_DATA-1:0] model [8];

   spi_slave_regfile #(.W_DATA(W_DATA), .W_ADDR(W_ADDR), .W_CMD(W_CMD)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      wr_seen  = wr_seen + int'(wr_valid);
      err_seen = err_seen + int'(frame_err);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ld_write(input logic [2:0] a, input logic [31:0] d);
      ld_addr = a;
      ld_data = d;
      ld_en   = 1'b1;
      wait_clk(1);
      ld_en   = 1'b0;
      model[a] = d;
   endtask

   // Clocks nbits bits of {cmd,data} (extras random); optional ld pulse lands in the commit clk.
   task automatic shift_bits(input logic [39:0] word, input int nbits, input bit inject,
                             input logic [31:0] inj_data, output logic [31:0] rx);
      rx = '0;
      for (int i = 0; i < nbits; i++) begin
         mosi = (i < 40) ? word[39-i] : 1'($urandom);
         wait_clk(5);
         if (i >= 8 && i < 40) rx = {rx[30:0], miso};
         if (i == 8) check("miso_oe_active", 32'(miso_oe), 32'd1);
         sclk = 1'b1;
         if (inject && i == 39) begin
            wait_clk(3);
            ld_addr = word[34:32];
            ld_data = inj_data;
            ld_en   = 1'b1;
            wait_clk(1);
            check("collision_same_clk", 32'(wr_valid), 32'd1);
            ld_en = 1'b0;
            wait_clk(1);
         end else begin
            wait_clk(5);
         end
         sclk = 1'b0;
      end
   endtask

   task automatic do_frame(input logic [7:0] cmd, input logic [31:0] data, input int nbits,
                           input bit inject, input logic [31:0] inj_data);
      logic [31:0] rx;
      logic [2:0]  a;
      int          err0, wr0;
      bit          cmd_ok, complete, is_wr, is_rd;
      a        = cmd[2:0];
      cmd_ok   = (nbits >= 8) && (cmd[6:3] == 4'd0);
      complete = (nbits >= 40);
      is_wr    = cmd_ok && complete && !cmd[7];
      is_rd    = cmd_ok && complete && cmd[7];
      err0     = err_seen;
      wr0      = wr_seen;
      cs_n = 1'b0;
      wait_clk(5);
      shift_bits({cmd, data}, nbits, inject, inj_data, rx);
      cs_n = 1'b1;
      wait_clk(8);
      check("frame_err_count", 32'(err_seen - err0), (cmd_ok && complete) ? 32'd0 : 32'd1);
      check("wr_valid_count", 32'(wr_seen - wr0), is_wr ? 32'd1 : 32'd0);
      check("miso_oe_idle", 32'(miso_oe), 32'd0);
      if (is_wr) begin
         check("wr_addr", 32'(wr_addr), 32'(a));
         check("wr_data", wr_data, data);
         model[a] = inject ? inj_data : data;
      end
      if (is_rd) check("read_data", rx, model[a]);
   endtask

   initial begin
      logic [31:0] rx;
      logic [2:0]  a;
      int          kind;

      rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      for (int i = 0; i < 8; i++) model[i] = '0;
      wait_clk(3);
      check("rst_miso", 32'(miso), 32'd0);
      check("rst_miso_oe", 32'(miso_oe), 32'd0);
      check("rst_wr_valid", 32'(wr_valid), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", wr_data, 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      rst = 1'b0;
      wait_clk(3);

      do_frame(8'h05, 32'hDEADBEEF, 40, 1'b0, '0);
      do_frame(8'h85, 32'h0, 40, 1'b0, '0);

      ld_write(3'd2, 32'h12345678);
      do_frame(8'h82, 32'h0, 40, 1'b0, '0);

      ld_write(3'd3, 32'h0BADF00D);
      do_frame(8'h03, 32'hCAFEF00D, 28, 1'b0, '0);
      do_frame(8'h83, 32'h0, 40, 1'b0, '0);

      do_frame(8'h48, 32'hFFFFFFFF, 40, 1'b0, '0);
      do_frame(8'h80, 32'h0, 40, 1'b0, '0);

      do_frame(8'h01, 32'h00005555, 40, 1'b1, 32'hAAAA0000);
      do_frame(8'h81, 32'h0, 40, 1'b0, '0);

      do_frame(8'h04, 32'h13579BDF, 44, 1'b0, '0);
      do_frame(8'h84, 32'h0, 43, 1'b0, '0);

      cs_n = 1'b0;
      wait_clk(5);
      shift_bits({8'h82, 32'h0}, 20, 1'b0, '0, rx);
      wait_clk(2);
      check("oe_before_rst", 32'(miso_oe), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("midframe_rst_miso", 32'(miso), 32'd0);
      check("midframe_rst_oe", 32'(miso_oe), 32'd0);
      check("midframe_rst_wr_data", wr_data, 32'd0);
      cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
      for (int i = 0; i < 8; i++) model[i] = '0;
      wait_clk(3);
      rst = 1'b0;
      wait_clk(3);
      do_frame(8'h07, 32'h600DCAFE, 40, 1'b0, '0);
      do_frame(8'h87, 32'h0, 40, 1'b0, '0);
      do_frame(8'h82, 32'h0, 40, 1'b0, '0);

      for (int k = 0; k < 30; k++) begin
         kind = int'($urandom_range(0, 4));
         a    = 3'($urandom);
         case (kind)
            0: do_frame({5'b0, a}, $urandom, 40 + int'($urandom_range(0, 3)), 1'b0, '0);
            1: do_frame({5'b10000, a}, $urandom, 40 + int'($urandom_range(0, 3)), 1'b0, '0);
            2: do_frame({1'($urandom), 4'($urandom_range(1, 15)), a}, $urandom, 40, 1'b0, '0);
            3: do_frame({1'($urandom), 4'b0, a}, $urandom, int'($urandom_range(1, 39)), 1'b0, '0);
            default: ld_write(a, $urandom);
         endcase
      end

      for (int r = 0; r < 8; r++) do_frame({5'b10000, 3'(r)}, 32'h0, 40, 1'b0, '0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
